// File: rtl/nabp_state_pkg.sv
// Shared types and helpers for the NABP multi-bank state control.
// The bank state encoding is visible so checkers can bind to it directly.
package nabp_state_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        FILL       = 3'd2,
        FILL_DONE  = 3'd3,
        SHIFT      = 3'd4,
        SHIFT_DONE = 3'd5
    } bank_state_e;

    localparam int kDefaultAngleLength = 9;

    // Width needed to index n items, never less than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nabp_bank_fsm.sv
// Per-bank fill/shift sequencer. Moore outputs decoded from the state register,
// which is also exported for observation.
module nabp_bank_fsm
    import nabp_state_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue,
    input  logic       shift_grant,
    input  logic       fill_done,
    input  logic       shift_done,
    output logic [2:0] state,
    output logic       fill_enable,
    output logic       shift_enable,
    output logic       shift_finished,
    output logic       idle
);

    bank_state_e state_q;
    bank_state_e state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done strobes only matter in the state that waits for them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (issue)       state_d = SETUP;
            SETUP:                       state_d = FILL;
            FILL:       if (fill_done)   state_d = FILL_DONE;
            FILL_DONE:  if (shift_grant) state_d = SHIFT;
            SHIFT:      if (shift_done)  state_d = SHIFT_DONE;
            SHIFT_DONE:                  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_enable    = 1'b0;
        shift_enable   = 1'b0;
        shift_finished = 1'b0;
        idle           = 1'b0;
        case (state_q)
            IDLE:       idle           = 1'b1;
            FILL:       fill_enable    = 1'b1;
            SHIFT:      shift_enable   = 1'b1;
            SHIFT_DONE: shift_finished = 1'b1;
            default:    ;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/nabp_multi_state_control.sv
// Sequences kNumBanks shifter banks: issues angles round-robin, lets fills overlap,
// and serialises shifts in issue order behind the downstream ready.
module nabp_multi_state_control
    import nabp_state_pkg::*;
#(
    parameter int kNumBanks    = 2,
    parameter int kAngleLength = kDefaultAngleLength,
    parameter int kNumAngles   = 180,
    parameter int kAngleStart  = 0,
    parameter int kAngleStep   = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              pe_ready,
    input  logic [kNumBanks-1:0]              sh_fill_done,
    input  logic [kNumBanks-1:0]              sh_shift_done,
    output logic [kNumBanks-1:0]              sh_fill_enable,
    output logic [kNumBanks-1:0]              sh_shift_enable,
    output logic [kNumBanks*kAngleLength-1:0] angle,
    output logic                              busy,
    output logic                              done,
    output logic [kNumBanks*3-1:0]            bank_state
);

    localparam int kPtrW = ptr_width(kNumBanks);
    localparam int kRemW = ptr_width(kNumAngles + 1);
    localparam logic [kAngleLength-1:0] kStartVal = kAngleLength'(kAngleStart);
    localparam logic [kAngleLength-1:0] kStepVal  = kAngleLength'(kAngleStep);

    logic [kAngleLength-1:0] next_angle;
    logic [kRemW-1:0]        remaining;
    logic [kPtrW-1:0]        issue_ptr;
    logic [kPtrW-1:0]        shift_ptr;
    logic [kAngleLength-1:0] angle_q [kNumBanks];

    logic [kNumBanks-1:0] issue_vec;
    logic [kNumBanks-1:0] grant_vec;
    logic [kNumBanks-1:0] bank_idle;
    logic [kNumBanks-1:0] bank_finished;
    logic                 issue_ok;
    logic                 issue_fire;
    logic                 all_idle;
    logic                 shift_step;

    function automatic logic [kPtrW-1:0] ptr_inc(input logic [kPtrW-1:0] p);
        return (p == kPtrW'(kNumBanks - 1)) ? '0 : p + kPtrW'(1);
    endfunction

    assign issue_ok   = busy && (remaining != '0);
    assign issue_fire = |issue_vec;
    assign all_idle   = &bank_idle;
    assign shift_step = |bank_finished;

    // Handshake: a bank leaves FILL_DONE only in a cycle where shift_ptr selects it
    // and pe_ready is high; sh_fill_done / sh_shift_done are sampled only in FILL / SHIFT.
    for (genvar b = 0; b < kNumBanks; b++) begin : g_bank
        logic [2:0] st;

        assign issue_vec[b] = issue_ok && (issue_ptr == kPtrW'(b)) && bank_idle[b];
        assign grant_vec[b] = pe_ready && (shift_ptr == kPtrW'(b));

        nabp_bank_fsm u_bank (
            .clk            (clk),
            .reset_n        (reset_n),
            .issue          (issue_vec[b]),
            .shift_grant    (grant_vec[b]),
            .fill_done      (sh_fill_done[b]),
            .shift_done     (sh_shift_done[b]),
            .state          (st),
            .fill_enable    (sh_fill_enable[b]),
            .shift_enable   (sh_shift_enable[b]),
            .shift_finished (bank_finished[b]),
            .idle           (bank_idle[b])
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                angle_q[b] <= '0;
            end else if (issue_vec[b]) begin
                angle_q[b] <= next_angle;
            end
        end

        assign angle[b*kAngleLength +: kAngleLength] = angle_q[b];
        assign bank_state[b*3 +: 3]                  = st;
    end

    // Completion needs every bank drained, so the last shift_done retires before done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            next_angle <= kStartVal;
            issue_ptr  <= '0;
            shift_ptr  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy       <= 1'b1;
                    remaining  <= kRemW'(kNumAngles);
                    next_angle <= kStartVal;
                    issue_ptr  <= '0;
                    shift_ptr  <= '0;
                end
            end else if ((remaining == '0) && all_idle) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                if (issue_fire) begin
                    next_angle <= next_angle + kStepVal;
                    remaining  <= remaining - kRemW'(1);
                    issue_ptr  <= ptr_inc(issue_ptr);
                end
                if (shift_step) begin
                    shift_ptr <= ptr_inc(shift_ptr);
                end
            end
        end
    end

endmodule

// File: tb/tb_nabp_multi_state_control.sv
// Directed bench for the multi-bank state control: three configurations, an
// auto-responding shifter model and a scoreboard of expected {bank, angle} shifts.
`timescale 1ns/1ps
module tb_nabp_multi_state_control;
    import nabp_state_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pe_ready = 1'b0;
    logic       start [3];
    logic [1:0] fd [3];
    logic [1:0] sd [3];
    logic [1:0] fe [3];
    logic [1:0] se [3];
    logic [17:0] ang [3];
    logic       busy [3];
    logic       done [3];
    logic [5:0] bst [3];

    int checks = 0;
    int failures = 0;
    int fill_lat [2];
    int shift_lat = 2;
    int fcnt [3][2];
    int scnt [3][2];
    int done_seen [3];
    logic [1:0] prev_se [3];
    logic [9:0] exp_q [$];
    logic [9:0] exp_w_q [$];

    always #5 clk = ~clk;

    nabp_multi_state_control #(.kNumBanks(2), .kAngleLength(9), .kNumAngles(4),
                               .kAngleStart(0), .kAngleStep(45)) dut (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .pe_ready(pe_ready),
        .sh_fill_done(fd[0]), .sh_shift_done(sd[0]), .sh_fill_enable(fe[0]),
        .sh_shift_enable(se[0]), .angle(ang[0]), .busy(busy[0]), .done(done[0]),
        .bank_state(bst[0]));

    nabp_multi_state_control #(.kNumBanks(2), .kAngleLength(9), .kNumAngles(0),
                               .kAngleStart(0), .kAngleStep(45)) dut_z (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .pe_ready(pe_ready),
        .sh_fill_done(fd[1]), .sh_shift_done(sd[1]), .sh_fill_enable(fe[1]),
        .sh_shift_enable(se[1]), .angle(ang[1]), .busy(busy[1]), .done(done[1]),
        .bank_state(bst[1]));

    nabp_multi_state_control #(.kNumBanks(2), .kAngleLength(9), .kNumAngles(4),
                               .kAngleStart(400), .kAngleStep(100)) dut_w (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .pe_ready(pe_ready),
        .sh_fill_done(fd[2]), .sh_shift_done(sd[2]), .sh_fill_enable(fe[2]),
        .sh_shift_enable(se[2]), .angle(ang[2]), .busy(busy[2]), .done(done[2]),
        .bank_state(bst[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Shifter model: done strobes after a programmable number of enabled cycles.
    initial begin
        fill_lat[0] = 3;
        fill_lat[1] = 3;
        for (int i = 0; i < 3; i++) begin
            fd[i] = 2'b00;
            sd[i] = 2'b00;
            for (int b = 0; b < 2; b++) begin
                fcnt[i][b] = 0;
                scnt[i][b] = 0;
            end
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                for (int b = 0; b < 2; b++) begin
                    if (fe[i][b]) fcnt[i][b]++; else fcnt[i][b] = 0;
                    if (se[i][b]) scnt[i][b]++; else scnt[i][b] = 0;
                    fd[i][b] = (fcnt[i][b] == fill_lat[b]);
                    sd[i][b] = (scnt[i][b] == shift_lat);
                end
            end
        end
    end

    // Monitor: every new shift_enable pops the scoreboard; every done is counted.
    initial begin
        logic [9:0] got;
        logic [9:0] req;
        int bk;
        for (int i = 0; i < 3; i++) begin
            prev_se[i] = 2'b00;
            done_seen[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if ((se[i] & ~prev_se[i]) != 2'b00) begin
                    bk = se[i][1] ? 1 : 0;
                    check("shift_onehot", 32'($onehot(se[i])), 1);
                    got = {bk[0], ang[i][bk*9 +: 9]};
                    if (i == 0 && exp_q.size() > 0) begin
                        req = exp_q.pop_front();
                        check("shift_order_main", got, req);
                    end else if (i == 2 && exp_w_q.size() > 0) begin
                        req = exp_w_q.pop_front();
                        check("shift_order_wrap", got, req);
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_shift dut=%0d actual_bank=%0d actual_angle=%0d required=none",
                                 i, bk, ang[i][bk*9 +: 9]);
                    end
                end
                if (done[i]) begin
                    done_seen[i]++;
                    check("busy_clear_with_done", busy[i], 0);
                end
                prev_se[i] = se[i];
            end
        end
    end

    task automatic push_main(input int b, input int a);
        exp_q.push_back({b[0], 9'(a)});
    endtask

    task automatic push_set();
        push_main(0, 0);
        push_main(1, 45);
        push_main(0, 90);
        push_main(1, 135);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        int c0;
        int n;
        c0 = done_seen[i];
        n = 0;
        while (done_seen[i] == c0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_seen[i] != c0), 1);
    endtask

    task automatic wait_state(input int i, input int b, input bank_state_e s,
                              input int budget, input string name);
        int n;
        n = 0;
        while (bst[i][b*3 +: 3] != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bst[i][b*3 +: 3] == s), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        pe_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fill_en", fe[0], 0);
        check("rst_shift_en", se[0], 0);
        check("rst_angle", ang[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_bank_state", bst[0], 0);
        reset_n = 1'b1;

        // Nominal set with latency checks and an ignored start while busy.
        push_set();
        base = done_seen[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("busy_after_e0", busy[0], 1);
        check("no_fill_after_e0", fe[0], 0);
        @(negedge clk);
        check("bank0_setup_e1", bst[0][2:0], SETUP);
        @(negedge clk);
        check("bank0_fill_en_e2", fe[0], 2'b01);
        check("bank1_setup_e2", bst[0][5:3], SETUP);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 300, "done_timeout_t1");
        repeat (10) @(negedge clk);
        check("single_done_t1", done_seen[0] - base, 1);
        check("queue_empty_t1", exp_q.size(), 0);
        check("final_angles_t1", ang[0], {9'd135, 9'd90});
        check("idle_busy_t1", busy[0], 0);

        // Bank1 fills first and must wait for bank0 to finish shifting.
        fill_lat[0] = 6;
        fill_lat[1] = 1;
        push_set();
        pulse_start(0);
        wait_state(0, 1, FILL_DONE, 20, "bank1_fill_done_t2");
        check("bank0_still_fill_t2", bst[0][2:0], FILL);
        check("no_shift_early_t2", se[0], 0);
        wait_done(0, 300, "done_timeout_t2");
        check("queue_empty_t2", exp_q.size(), 0);
        fill_lat[0] = 3;
        fill_lat[1] = 3;

        // Downstream stall holds bank0 in FILL_DONE.
        pe_ready = 1'b0;
        push_set();
        pulse_start(0);
        wait_state(0, 0, FILL_DONE, 30, "bank0_fill_done_t3");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_no_shift_t3", se[0], 0);
        end
        pe_ready = 1'b1;
        @(negedge clk);
        check("shift_after_ready_t3", se[0], 2'b01);
        wait_done(0, 300, "done_timeout_t3");
        check("queue_empty_t3", exp_q.size(), 0);

        // Zero-angle configuration completes one edge after start.
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("zero_busy_e0", busy[1], 1);
        check("zero_no_done_e0", done[1], 0);
        @(negedge clk);
        check("zero_done_e1", done[1], 1);
        check("zero_busy_e1", busy[1], 0);
        check("zero_no_fill", fe[1], 0);
        @(negedge clk);
        check("zero_done_single", done[1], 0);

        // Angle generator wraps modulo 512.
        exp_w_q.push_back({1'b0, 9'd400});
        exp_w_q.push_back({1'b1, 9'd500});
        exp_w_q.push_back({1'b0, 9'd88});
        exp_w_q.push_back({1'b1, 9'd188});
        pulse_start(2);
        wait_done(2, 300, "done_timeout_t5");
        check("queue_empty_t5", exp_w_q.size(), 0);

        // Asynchronous reset in the middle of a shift, then a clean restart.
        push_set();
        pulse_start(0);
        n = 0;
        while (se[0][0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_shift_t6", se[0][0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_shift_en", se[0], 0);
        check("rst_mid_fill_en", fe[0], 0);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_angle", ang[0], 0);
        check("rst_mid_state", bst[0], 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_set();
        pulse_start(0);
        wait_done(0, 300, "done_timeout_t6");
        check("queue_empty_t6", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nabp_multi_state_control.md
Name: nabp_multi_state_control

Overview:
- Parametrised successor of the NABP per-angle state control.
- Sequences kNumBanks shifter banks, each running its own fill/shift FSM (generalised ping-pong).
- Generates the angle sequence internally and serialises shifting across banks in angle-issue order.
- Gates each shift on downstream readiness and reports completion of a full projection set.

Parameters:
- kNumBanks, 2, number of shifter banks sequenced; must be at least 1.
- kAngleLength, 9, width of each angle value.
- kNumAngles, 180, angles issued per start (0 allowed).
- kAngleStart, 0, first angle issued.
- kAngleStep, 1, increment between issued angles; addition is modulo 2^kAngleLength.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a projection set; ignored while busy.
- pe_ready  in  1  downstream ready; a bank may begin shifting only while this is high.
- sh_fill_done  in  kNumBanks  per-bank fill complete.
- sh_shift_done  in  kNumBanks  per-bank shift complete.
- sh_fill_enable  out  kNumBanks  per-bank fill enable.
- sh_shift_enable  out  kNumBanks  per-bank shift enable.
- angle  out  kNumBanks*kAngleLength  angle held by each bank; bank b occupies bits [b*kAngleLength +: kAngleLength].
- busy  out  1  set while a projection set is in progress.
- done  out  1  single-cycle pulse when the set is complete.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all outputs 0; all banks IDLE.
  - next_angle = kAngleStart; remaining = 0; issue_ptr = 0; shift_ptr = 0.
- Start:
  - start sampled with busy=0 at edge E0: busy=1, remaining=kNumAngles, next_angle=kAngleStart, issue_ptr=0, shift_ptr=0.
- Issue:
  - At most one bank is issued per edge.
  - Bank b is issued when busy=1, remaining>0, issue_ptr==b and bank b is IDLE.
  - On issue: angle[b] <= next_angle; next_angle += kAngleStep (mod 2^kAngleLength); remaining--; issue_ptr++ (wraps kNumBanks-1 -> 0).
- Bank FSM (one instance per bank; Moore outputs):
  - IDLE -> SETUP on issue.
  - SETUP -> FILL unconditionally (one cycle).
  - FILL: sh_fill_enable[b]=1; -> FILL_DONE when sh_fill_done[b]=1 is sampled. A done on the first FILL cycle counts.
  - FILL_DONE -> SHIFT when shift_ptr==b and pe_ready=1.
  - SHIFT: sh_shift_enable[b]=1; -> SHIFT_DONE when sh_shift_done[b]=1 is sampled.
  - SHIFT_DONE: shift_ptr++ (wraps); -> IDLE.
  - Illegal encoding -> IDLE.
- Ordering and concurrency:
  - Fills may overlap across banks.
  - At most one bank is in SHIFT at any time.
  - Shift order equals issue order.
- Ignored inputs: sh_fill_done outside FILL and sh_shift_done outside SHIFT have no effect.
- Latency from start at E0:
  - bank0 SETUP after E1; sh_fill_enable[0]=1 after E2.
  - bank1 SETUP after E2.
- Completion:
  - When busy=1, remaining==0 and every bank is IDLE, done=1 for exactly one cycle and busy clears on the same edge.
  - kNumAngles=0: done pulses at E1 after start.
- A bank returning to IDLE at edge Ek may be reissued at Ek+1 if issue_ptr points to it.
- start asserted in the same cycle as done is ignored (busy is still 1 at that edge).
- kNumBanks=1 degenerates to the single-bank sequence: setup -> fill -> fill_done -> shift -> shift_done -> setup.

Decomposition:
- Shared package nabp_state_pkg:
  - bank state enum: IDLE, SETUP, FILL, FILL_DONE, SHIFT, SHIFT_DONE (3-bit).
  - default angle width.
  - pointer-width function clog2(kNumBanks), minimum 1.
- Sub-module nabp_bank_fsm, one instance per bank.
  - Inputs: issue, shift_grant, fill_done, shift_done.
  - Outputs: state, fill_enable, shift_enable, shift_finished, idle.
- Top level: start/busy/done logic, angle generator, issue and shift pointers, angle registers.

Test Plan (kNumBanks=2, kAngleLength=9, kNumAngles=4, kAngleStep=45):
1. Start; fill_done 3 cycles after each fill_enable; shift_done 2 cycles after each shift_enable; pe_ready=1 -> banks receive angles 0,45,90,135 alternating bank0/bank1; shifts occur in that order; done pulses once; busy drops with done.
2. Bank1 fill_done arrives before bank0's -> bank1 waits in FILL_DONE (shift_enable[1]=0) until bank0 completes SHIFT_DONE; at most one shift_enable bit ever high.
3. pe_ready held 0 for 10 cycles with bank0 in FILL_DONE -> no shift_enable; shift_enable[0] rises the cycle after pe_ready returns to 1.
4. kNumAngles=0 -> done at E1 after start, no enables; start pulsed while busy in scenario 1 -> ignored, angle sequence unchanged.
5. kAngleStart=400, kAngleStep=100 -> angles 400, 500, 88, 188 (mod 512).
6. reset_n dropped mid-SHIFT -> all enables, busy and angle outputs 0 immediately; after release, a new start restarts cleanly at kAngleStart on bank0.
